// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation encoding, decode FSM states,
// the registered decode bundle and small opcode classification helpers.
package decode_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    alu_op_e     alu_op;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        reg_write;
    logic        illegal;
  } decode_bundle_t;

  function automatic logic known_opcode(input logic [6:0] opcode);
    return opcode inside {OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC};
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    return opcode inside {OP, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC};
  endfunction

  function automatic logic reads_rs1(input logic [6:0] opcode);
    return opcode inside {OP, OP_IMM, LOAD, STORE, BRANCH, JALR};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opcode);
    return opcode inside {OP, STORE, BRANCH};
  endfunction

  // alt selects SUB/SRA; callers decide whether instruction bit 30 is meaningful.
  function automatic alu_op_e funct_alu_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e branch_alu_op(input logic [2:0] funct3);
    case (funct3[2:1])
      2'b10:   return ALU_SLT;
      2'b11:   return ALU_SLTU;
      default: return ALU_SUB;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Pure combinational RV32I immediate extraction; format chosen by opcode, result sign-extended.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [31:0] imm
);

  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
    imm = '0;
    case (instruction[6:0])
      OP_IMM, LOAD, JALR:
        imm = {{20{instruction[31]}}, instruction[31:20]};
      STORE:
        imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      BRANCH:
        imm = {{19{instruction[31]}}, instruction[31], instruction[7],
               instruction[30:25], instruction[11:8], 1'b0};
      LUI, AUIPC:
        imm = {instruction[31:12], 12'b0};
      JAL:
        imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
               instruction[20], instruction[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: one-deep registered bundle, load-use stall with a one-cycle bubble, JAL redirect.
// Macro DECODE_STATIC_PREDICT_EN additionally redirects fetch on backward conditional branches.
module instruction_decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instruction,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        branch_present,
  output logic [31:0] branch_offset,
  input  logic        flush,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_imm,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [3:0]  id_alu_op,
  output logic        id_is_load,
  output logic        id_is_store,
  output logic        id_is_branch,
  output logic        id_reg_write,
  output logic        id_illegal
);

`ifdef DECODE_STATIC_PREDICT_EN
  localparam logic STATIC_PREDICT = 1'b1;
`else
  localparam logic STATIC_PREDICT = 1'b0;
`endif

  state_e         state_q, state_d;
  logic           valid_q, valid_d;
  decode_bundle_t bundle_q, bundle_d, dec;

  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic        hazard, transfer, redirect;

  imm_gen u_imm_gen (
    .instruction (if_instruction),
    .imm         (imm)
  );

  assign opcode = if_instruction[6:0];
  assign rd     = if_instruction[11:7];
  assign funct3 = if_instruction[14:12];
  assign rs1    = if_instruction[19:15];
  assign rs2    = if_instruction[24:20];
  assign alt    = if_instruction[30];

  always_comb begin
    dec           = '0;
    dec.pc        = if_pc;
    dec.imm       = imm;
    dec.rd        = rd;
    dec.rs1       = rs1;
    dec.rs2       = rs2;
    dec.is_load   = (opcode == LOAD);
    dec.is_store  = (opcode == STORE);
    dec.is_branch = opcode inside {BRANCH, JAL, JALR};
    dec.illegal   = !known_opcode(opcode);
    dec.reg_write = writes_rd(opcode) && (rd != 5'd0);
    case (opcode)
      OP:      dec.alu_op = funct_alu_op(funct3, alt);
      OP_IMM:  dec.alu_op = funct_alu_op(funct3, alt && (funct3 == 3'b101));
      BRANCH:  dec.alu_op = branch_alu_op(funct3);
      LUI:     dec.alu_op = ALU_PASS_B;
      default: dec.alu_op = ALU_ADD;
    endcase
  end

  // The held load's result is not forwardable yet, so a dependent consumer must wait.
  assign hazard = if_valid && valid_q && bundle_q.is_load && (bundle_q.rd != 5'd0) &&
                  ((reads_rs1(opcode) && (rs1 == bundle_q.rd)) ||
                   (reads_rs2(opcode) && (rs2 == bundle_q.rd)));

  assign if_ready = !rst && !flush && (!valid_q || id_ready) && (state_q == RUN) && !hazard;
  assign transfer = if_valid && if_ready;

  assign redirect       = (opcode == JAL) || (STATIC_PREDICT && (opcode == BRANCH) && imm[31]);
  assign branch_present = transfer && redirect;
  assign branch_offset  = branch_present ? imm : 32'd0;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
      state_d = RUN;
    end else begin
      if (transfer) begin
        bundle_d = dec;
        valid_d  = 1'b1;
      end else if (id_ready) begin
        valid_d  = 1'b0;
      end
      if (state_q == BUBBLE) begin
        state_d = RUN;
      end else if (hazard && id_ready) begin
        state_d = BUBBLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= RUN;
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign id_valid     = valid_q;
  assign id_pc        = bundle_q.pc;
  assign id_imm       = bundle_q.imm;
  assign id_rd        = bundle_q.rd;
  assign id_rs1       = bundle_q.rs1;
  assign id_rs2       = bundle_q.rs2;
  assign id_alu_op    = bundle_q.alu_op;
  assign id_is_load   = bundle_q.is_load;
  assign id_is_store  = bundle_q.is_store;
  assign id_is_branch = bundle_q.is_branch;
  assign id_reg_write = bundle_q.reg_write;
  assign id_illegal   = bundle_q.illegal;

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port if_valid, input, 1 bit: the fetch stage presents an instruction.
REQ-004 SHALL have port if_instruction, input, 32 bits: RV32I instruction word.
REQ-005 SHALL have port if_pc, input, 32 bits: byte address of if_instruction.
REQ-006 SHALL have port if_ready, output, 1 bit: the stage accepts the instruction this cycle.
REQ-007 SHALL have port branch_present, output, 1 bit: redirects fetch to PC+branch_offset.
REQ-008 SHALL have port branch_offset, output, 32 bits: signed byte offset for fetch.
REQ-009 SHALL have port flush, input, 1 bit: the execute stage cancels the decode contents.
REQ-010 SHALL have port id_ready, input, 1 bit: the execute stage accepts the decoded bundle.
REQ-011 SHALL have port id_valid, output, 1 bit: the decoded bundle is valid.
REQ-012 SHALL have ports id_pc[31:0], id_imm[31:0], id_rd/id_rs1/id_rs2[4:0], id_alu_op[3:0], id_is_load, id_is_store, id_is_branch, id_reg_write and id_illegal as registered outputs.

Function
REQ-013 Transfer on the input side SHALL occur when if_valid && if_ready.
- Accepted instruction → decoded bundle registered with id_valid=1 on the next edge.
- Latency is 1 cycle.
REQ-014 if_ready SHALL equal (!id_valid || id_ready) && state==RUN && !hazard.
REQ-015 The output bundle SHALL be held stable while id_valid && !id_ready.
REQ-016 When id_ready=1 and no new transfer occurs, id_valid SHALL clear next cycle.
REQ-017 id_imm SHALL be sign-extended per I/S/B/U/J format; B and J immediates carry bit0=0.
REQ-018 Unknown opcode SHALL set id_illegal=1, id_reg_write=0, id_is_load=0, id_is_store=0.
REQ-019 rd==0 SHALL force id_reg_write=0.
REQ-020 Load-use hazard SHALL be detected when all of the following hold: id_valid, id_is_load, id_rd!=0, and the incoming instruction's rs1 or rs2 uses id_rd.
REQ-021 FSM states SHALL be RUN and BUBBLE.
- On hazard in RUN: if_ready=0 and id_valid=0 once the load leaves; go to BUBBLE.
- BUBBLE → RUN after exactly one cycle.
REQ-022 branch_present SHALL be a combinational one-cycle pulse on a transfer of JAL, with branch_offset=J-immediate.
- Otherwise branch_present=0 and branch_offset=0.
REQ-023 JALR and conditional branches SHALL NOT assert branch_present (resolved in execute), except as allowed by REQ-027.
REQ-024 flush SHALL have priority over all other events.
- id_valid=0 next cycle; any same-cycle transfer is dropped; FSM → RUN.
- if_ready=0 and branch_present=0 during the flush cycle.

Reset
REQ-025 While rst=1 at a clock edge: id_valid=0, all id_* fields=0, state=RUN.
- if_ready=0 and branch_present=0 for that cycle.
REQ-026 Reset SHALL take priority over flush and over an in-progress BUBBLE.

Configuration
REQ-027 Macro DECODE_STATIC_PREDICT_EN controls static prediction of conditional branches.
- Defined: a transfer of a conditional branch with negative B-immediate also asserts branch_present with branch_offset=B-immediate.
- Undefined: only JAL asserts branch_present.
- id_is_branch=1 in both cases.

Structure
REQ-028 Package decode_pkg SHALL hold:
- opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
- the alu_op enum (4 bits);
- the FSM state typedef.
REQ-029 Immediate extraction SHALL reside in sub-module imm_gen (pure combinational, instruction → 32-bit imm).

Verification
REQ-030 Scenario addi: 0x00500093 at pc=0x0 → next cycle id_valid=1, id_rd=1, id_imm=5, id_reg_write=1.
REQ-031 Scenario load-use: lw 0x0000A103, then add 0x001101B3 → exactly one bubble cycle (id_valid=0, if_ready=0), then add issues.
REQ-032 Scenario jal: jal x0,-8 (0xFF9FF06F) → branch_present=1 for one cycle, branch_offset=0xFFFFFFF8, id_reg_write=0.
REQ-033 Scenario beq: beq x0,x0,-4 (0xFE000EE3) → branch_present=1, offset=0xFFFFFFFC with macro; 0 without.
REQ-034 Scenario backpressure plus flush: id_ready=0 for 3 cycles → bundle stable; flush concurrent with if_valid → id_valid=0 next cycle, instruction dropped.
REQ-035 Scenario illegal: opcode 0x7F → id_illegal=1, id_reg_write=0; rst mid-BUBBLE → state RUN, id_valid=0.
